demux32_1to4_stage: RTL
=======================

Name: demux32_1to4_stage

Overview:
- Registered 1-to-4 steering stage, the distribution counterpart of the 32-bit 4:1 select path.
- One producer word is routed to one of four consumer lanes by {sel1,sel2}.
- Each lane has a one-entry holding register with a valid/ready handshake.
- Sits between the datapath result bus and four write-back/forwarding consumers, and keeps per-lane delivery counts for debug.

Parameters:
- WIDTH, 32, data width of the input and each lane.
- CNT_W, 8, width of each per-lane delivered-word counter.

Ports:
- clk  input  1  system clock, rising edge.
- rst_n  input  1  reset, asynchronous, active-low.
- in_valid  input  1  producer offers in_data this cycle.
- in_ready  output  1  stage accepts the offered word this cycle.
- in_data  input  WIDTH  producer word.
- sel1  input  1  lane index MSB; sampled with in_data.
- sel2  input  1  lane index LSB; lane = {sel1,sel2}: 00→lane1, 01→lane2, 10→lane3, 11→lane4.
- out1_valid .. out4_valid  output  1 each  lane holding register full.
- out1_ready .. out4_ready  input  1 each  lane consumer takes the word this cycle.
- out1_data .. out4_data  output  WIDTH each  lane holding register contents.
- cnt1 .. cnt4  output  CNT_W each  words delivered on the lane, i.e. outN_valid & outN_ready events.

Behaviour:
- Reset (rst_n low, asynchronous): all outN_valid=0, outN_data=0, cntN=0. in_ready reads 0 while rst_n is low. Normal operation resumes on the first rising edge after deassertion.
- Lane index L = {sel1,sel2}, combinational from the current inputs. sel1/sel2 are don't-care when in_valid=0.
- in_ready = rst_n & (!outL_valid | outL_ready). It depends only on the selected lane. A full lane being drained in the same cycle accepts the new word (pass-through refill, no bubble).
- Accept event: in_valid & in_ready. On that edge outL_data ← in_data and outL_valid ← 1.
- Drain event on lane N: outN_valid & outN_ready. On that edge outN_valid ← 0 unless the same edge also accepts into lane N; then valid stays 1 and data is replaced.
- outN_ready while outN_valid=0 has no effect: no state change, no count.
- Latency: a word accepted at edge k is visible on outL_data/outL_valid after edge k, one cycle.
- Only lane L can be written per cycle. Other lanes drain independently and concurrently; up to four drains can occur in one cycle.
- Stall: in_valid=1 with lane L full and outL_ready=0 gives in_ready=0. The producer must hold in_data/sel stable until accepted. The stage does not check this; it is a producer obligation, asserted in the bench.
- Head-of-line: a stalled word for lane L blocks the producer even if other lanes are empty. This is intended; there is no reordering.
- Data stability: outN_data is constant while outN_valid=1 and no drain occurs.
- Counters: cntN increments by 1 on each lane-N drain and wraps 2^CNT_W−1 → 0 silently.
- Width rule: all data paths are exactly WIDTH bits, with no extension or truncation. All 32 bits, index 0..WIDTH−1, are steered.
- No internal FSM beyond the four per-lane valid bits. Each lane's state is EMPTY (valid=0) or FULL (valid=1):
  - EMPTY→FULL on accept.
  - FULL→EMPTY on drain without accept.
  - FULL→FULL on drain+accept, or on hold.

Decomposition:
- Shared package holds:
  - lane index constants LANE1=2'b00, LANE2=2'b01, LANE3=2'b10, LANE4=2'b11;
  - default WIDTH=32 and CNT_W=8.
- One sub-module is natural: lane_hold_reg.
  - Contents: one holding register with valid bit, write-enable, ready and counter.
  - Instantiated four times from a generate loop indexed by lane.
  - The top module only decodes {sel1,sel2} into four write-enables and muxes the selected lane's full/ready into in_ready.

Test Plan:
1. Reset mid-operation: fill lanes 1 and 3 (out1_data=32'hDEADBEEF, out3_data=32'h0000_0001), pulse rst_n low between edges → all valid=0, data=0, cnt=0 immediately, without waiting for a clock edge.
2. Steering sweep: out*_ready=1, send 32'h11111111/22222222/33333333/44444444 with sel {00,01,10,11} on consecutive cycles → each word appears on out1..out4 respectively one cycle later. cnt1..cnt4=1 each; in_ready stays 1.
3. Back-pressure: out2_ready=0, send 32'hA5A5A5A5 then 32'h5A5A5A5A to lane2 → second word sees in_ready=0 and out2_data holds A5A5A5A5. Raise out2_ready → same edge drains A5A5A5A5 and loads 5A5A5A5A, out2_valid stays 1, cnt2=1.
4. Head-of-line: lane4 full and stalled, producer targets lane4 → in_ready=0. Meanwhile lane1, full with 32'hCAFEF00D, drains with out1_ready=1 → cnt1 increments and lane4 is unchanged.
5. Counter wrap: 256 drains on lane3 with CNT_W=8 → cnt3 returns to 0. One more drain → cnt3=1; other counters unchanged.
6. Spurious ready: all lanes empty, all outN_ready=1, in_valid=0 for 10 cycles → no valid asserted, all counters stay 0.

Source files
------------

// File: rtl/demux32_1to4_stage_pkg.sv
// Shared definitions for the 1-to-4 steering stage: lane indices,
// default sizes and the lane-index decoder.
package demux32_1to4_stage_pkg;

  localparam logic [1:0] LANE1 = 2'b00;
  localparam logic [1:0] LANE2 = 2'b01;
  localparam logic [1:0] LANE3 = 2'b10;
  localparam logic [1:0] LANE4 = 2'b11;

  localparam int DEF_WIDTH = 32;
  localparam int DEF_CNT_W = 8;

  // One-hot write-enable pattern for a lane index; bit 0 is lane1.
  function automatic logic [3:0] lane_onehot(input logic [1:0] lane);
    logic [3:0] oh;
    case (lane)
      LANE1:   oh = 4'b0001;
      LANE2:   oh = 4'b0010;
      LANE3:   oh = 4'b0100;
      LANE4:   oh = 4'b1000;
      default: oh = 4'b0000;
    endcase
    return oh;
  endfunction

endpackage

// File: rtl/demux32_1to4_stage_lane_hold_reg.sv
// One consumer lane: a single-entry holding register with valid bit,
// a write port from the steering logic and a delivered-word counter.
module lane_hold_reg
  import demux32_1to4_stage_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH,
  parameter int CNT_W = DEF_CNT_W
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             i_wr_en,
  input  logic [WIDTH-1:0] i_wr_data,
  input  logic             i_rd_ready,
  output logic             o_valid,
  output logic [WIDTH-1:0] o_data,
  output logic [CNT_W-1:0] o_cnt
);

  logic             r_valid;
  logic [WIDTH-1:0] r_data;
  logic [CNT_W-1:0] r_cnt;
  logic             w_drain;

  // A drain only happens when the register actually holds a word.
  assign w_drain = r_valid & i_rd_ready;

  // Holding register: a write wins over a same-cycle drain, so a draining
  // lane refills without a bubble.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_valid <= 1'b0;
      r_data  <= {WIDTH{1'b0}};
    end else if (i_wr_en) begin
      r_valid <= 1'b1;
      r_data  <= i_wr_data;
    end else if (w_drain) begin
      r_valid <= 1'b0;
      r_data  <= r_data;
    end else begin
      r_valid <= r_valid;
      r_data  <= r_data;
    end
  end

  // Delivered-word counter; wraps silently at its width.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cnt <= {CNT_W{1'b0}};
    end else if (w_drain) begin
      r_cnt <= r_cnt + CNT_W'(1);
    end else begin
      r_cnt <= r_cnt;
    end
  end

  assign o_valid = r_valid;
  assign o_data  = r_data;
  assign o_cnt   = r_cnt;

endmodule

// File: rtl/demux32_1to4_stage.sv
// Registered 1-to-4 steering stage: routes one producer word per cycle into
// the lane chosen by {sel1,sel2}; each lane is an independent holding register.
module demux32_1to4_stage
  import demux32_1to4_stage_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH,
  parameter int CNT_W = DEF_CNT_W
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  input  logic             sel1,
  input  logic             sel2,
  output logic             out1_valid,
  output logic             out2_valid,
  output logic             out3_valid,
  output logic             out4_valid,
  input  logic             out1_ready,
  input  logic             out2_ready,
  input  logic             out3_ready,
  input  logic             out4_ready,
  output logic [WIDTH-1:0] out1_data,
  output logic [WIDTH-1:0] out2_data,
  output logic [WIDTH-1:0] out3_data,
  output logic [WIDTH-1:0] out4_data,
  output logic [CNT_W-1:0] cnt1,
  output logic [CNT_W-1:0] cnt2,
  output logic [CNT_W-1:0] cnt3,
  output logic [CNT_W-1:0] cnt4
);

  logic [1:0]       w_lane;
  logic [3:0]       w_wr_en;
  logic [3:0]       w_lane_valid;
  logic [3:0]       w_lane_ready;
  logic [WIDTH-1:0] w_lane_data [4];
  logic [CNT_W-1:0] w_lane_cnt  [4];
  logic             w_sel_full;
  logic             w_sel_ready;
  logic             w_accept;

  assign w_lane       = {sel1, sel2};
  assign w_lane_ready = {out4_ready, out3_ready, out2_ready, out1_ready};

  // Full/ready of the selected lane only; other lanes never block the producer
  // and a stalled lane blocks it even if others are empty (no reordering).
  always_comb begin
    w_sel_full  = 1'b0;
    w_sel_ready = 1'b0;
    case (w_lane)
      LANE1: begin
        w_sel_full  = w_lane_valid[0];
        w_sel_ready = w_lane_ready[0];
      end
      LANE2: begin
        w_sel_full  = w_lane_valid[1];
        w_sel_ready = w_lane_ready[1];
      end
      LANE3: begin
        w_sel_full  = w_lane_valid[2];
        w_sel_ready = w_lane_ready[2];
      end
      LANE4: begin
        w_sel_full  = w_lane_valid[3];
        w_sel_ready = w_lane_ready[3];
      end
      default: begin
        w_sel_full  = 1'b0;
        w_sel_ready = 1'b0;
      end
    endcase
  end

  // rst_n gates in_ready so nothing is offered as accepted during reset.
  assign in_ready = rst_n & (~w_sel_full | w_sel_ready);
  assign w_accept = in_valid & in_ready;
  assign w_wr_en  = w_accept ? lane_onehot(w_lane) : 4'b0000;

  for (genvar g = 0; g < 4; g++) begin : g_lane
    lane_hold_reg #(
      .WIDTH (WIDTH),
      .CNT_W (CNT_W)
    ) u_lane (
      .clk        (clk),
      .rst_n      (rst_n),
      .i_wr_en    (w_wr_en[g]),
      .i_wr_data  (in_data),
      .i_rd_ready (w_lane_ready[g]),
      .o_valid    (w_lane_valid[g]),
      .o_data     (w_lane_data[g]),
      .o_cnt      (w_lane_cnt[g])
    );
  end

  assign out1_valid = w_lane_valid[0];
  assign out2_valid = w_lane_valid[1];
  assign out3_valid = w_lane_valid[2];
  assign out4_valid = w_lane_valid[3];
  assign out1_data  = w_lane_data[0];
  assign out2_data  = w_lane_data[1];
  assign out3_data  = w_lane_data[2];
  assign out4_data  = w_lane_data[3];
  assign cnt1       = w_lane_cnt[0];
  assign cnt2       = w_lane_cnt[1];
  assign cnt3       = w_lane_cnt[2];
  assign cnt4       = w_lane_cnt[3];

endmodule
